// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline and the hazard control unit: instruction
// registers and memory handshake in, per-stage stall/flush controls out.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      if_id_ir;
  logic [31:0]      id_ex_ir;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             flush_id;
  logic             flush_ex;
  logic             bubble_wb;
  logic [1:0]       fsm_state;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_timeout;

  // The pipeline side drives instructions and the memory handshake.
  modport master (
    output if_id_ir, id_ex_ir, branch_taken, dmem_req, dmem_ready,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           bubble_wb, fsm_state, stall_cycles, mem_timeout
  );

  modport slave (
    input  if_id_ir, id_ex_ir, branch_taken, dmem_req, dmem_ready,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           bubble_wb, fsm_state, stall_cycles, mem_timeout
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Interlock controller for the 5-stage RV32I pipeline: load-use stalls,
// branch flushes, data-memory wait freezes and a memory timeout trap.
module hazard_control_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_control_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2,
    ST_UNUSED   = 2'd3
  } state_t;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      wait_cnt;
  logic [15:0]      wait_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_q;

  logic [6:0] ex_op;
  logic [4:0] ex_rd;
  logic [6:0] id_op;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       load_use;
  logic       freeze_req;

  logic stall_if;
  logic stall_id;
  logic stall_ex;
  logic stall_mem;
  logic flush_id;
  logic flush_ex;
  logic bubble_wb;

  logic unused_ir_bits;

  assign ex_op  = bus.id_ex_ir[6:0];
  assign ex_rd  = bus.id_ex_ir[11:7];
  assign id_op  = bus.if_id_ir[6:0];
  assign id_rs1 = bus.if_id_ir[19:15];
  assign id_rs2 = bus.if_id_ir[24:20];

  assign unused_ir_bits = ^{bus.id_ex_ir[31:12], bus.if_id_ir[31:25],
                            bus.if_id_ir[14:7]};

  // Only formats that really read a register field may trigger a stall, so
  // immediate bits of LUI/AUIPC/JAL that alias rs1/rs2 are ignored.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (id_op)
      OP_OP, OP_STORE, OP_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_OPIMM, OP_LOAD, OP_JALR: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign load_use = (ex_op == OP_LOAD) && (ex_rd != 5'd0) &&
                    ((rs1_used && (id_rs1 == ex_rd)) ||
                     (rs2_used && (id_rs2 == ex_rd)));

  assign freeze_req = bus.dmem_req && !bus.dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // The wait counter includes the RUN cycle that first saw the miss, so
  // MEM_WAIT holds for at most TIMEOUT cycles before trapping.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_RUN: begin
        if (freeze_req) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          if (wait_cnt == TIMEOUT_CNT) begin
            state_nxt = ST_ERROR;
          end else begin
            wait_cnt_nxt = wait_cnt + 16'd1;
          end
        end else begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // A freeze outranks branch and load-use; a pending branch stays valid in
  // the held EX stage and is acted on once the freeze lifts.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    bubble_wb = 1'b0;
    if (!rst) begin
      if ((state == ST_ERROR) ||
          ((state == ST_RUN) && freeze_req) ||
          ((state == ST_MEM_WAIT) && !bus.dmem_ready)) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        bubble_wb = 1'b1;
      end else if ((state == ST_RUN) || (state == ST_MEM_WAIT)) begin
        if (bus.branch_taken) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (load_use) begin
          stall_if = 1'b1;
          flush_ex = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (stall_if && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (state_nxt == ST_ERROR) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.stall_if     = stall_if;
  assign bus.stall_id     = stall_id;
  assign bus.stall_ex     = stall_ex;
  assign bus.stall_mem    = stall_mem;
  assign bus.flush_id     = flush_id;
  assign bus.flush_ex     = flush_ex;
  assign bus.bubble_wb    = bubble_wb;
  assign bus.fsm_state    = state;
  assign bus.stall_cycles = stall_cnt;
  assign bus.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit with a short timeout
// and a narrow stall counter so trapping and saturation are reachable.
module tb_hazard_control_unit;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1000010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_FRZ  = 7'b1111001;
  localparam logic [31:0] NOP   = 32'd0;

  typedef struct {
    string      tag;
    logic       rst;
    logic [6:0] ctl;
    logic [1:0] st;
    logic [3:0] cnt;
    logic       to;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_cnt;
  exp_t sb[$];

  hazard_control_unit_if #(.CNT_W(4)) bus ();

  hazard_control_unit #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] load(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] store(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  // LUI whose immediate bits alias rs1=x5
  function automatic logic [31:0] lui(input logic [4:0] rd);
    return {12'd0, 5'd5, 3'd0, rd, 7'b0110111};
  endfunction

  task automatic applyStimulus(input string tag, input logic r, input logic [31:0] id_ir,
                               input logic [31:0] ex_ir, input logic br, input logic req,
                               input logic rdy, input logic [6:0] ctl, input logic [1:0] st,
                               input logic to);
    exp_t e;
    rst              = r;
    bus.if_id_ir     = id_ir;
    bus.id_ex_ir     = ex_ir;
    bus.branch_taken = br;
    bus.dmem_req     = req;
    bus.dmem_ready   = rdy;
    if (r) exp_cnt = 0;
    e.tag = tag;
    e.rst = r;
    e.ctl = ctl;
    e.st  = st;
    e.cnt = 4'(exp_cnt);
    e.to  = to;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [6:0] ctl_obs;
    @(negedge clk);
    e = sb.pop_front();
    ctl_obs = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
               bus.flush_id, bus.flush_ex, bus.bubble_wb};
    checks++;
    assert (ctl_obs === e.ctl) else begin
      errors++;
      $error("[TB] FAIL %s ctl observed=%b expected=%b", e.tag, ctl_obs, e.ctl);
    end
    checks++;
    assert (bus.fsm_state === e.st) else begin
      errors++;
      $error("[TB] FAIL %s fsm_state observed=%0d expected=%0d", e.tag, bus.fsm_state, e.st);
    end
    checks++;
    assert (bus.stall_cycles === e.cnt) else begin
      errors++;
      $error("[TB] FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, bus.stall_cycles,
             e.cnt);
    end
    checks++;
    assert (bus.mem_timeout === e.to) else begin
      errors++;
      $error("[TB] FAIL %s mem_timeout observed=%b expected=%b", e.tag, bus.mem_timeout, e.to);
    end
    @(posedge clk);
    #1;
    if (!e.rst && e.ctl[6] && exp_cnt < 15) exp_cnt++;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;

    // Reset held with a live load-use pattern: every control stays low.
    applyStimulus("rst_hold", 1, r_type(6, 5, 2), load(5, 1), 0, 0, 0, C_NONE, 0, 0);
    checkOutput();

    applyStimulus("lu_rs1", 0, r_type(6, 5, 2), load(5, 1), 0, 0, 0, C_LU, 0, 0);
    checkOutput();
    applyStimulus("lu_after", 0, r_type(6, 5, 2), NOP, 0, 0, 0, C_NONE, 0, 0);
    checkOutput();
    applyStimulus("lu_rd_x0", 0, r_type(6, 0, 2), load(0, 1), 0, 0, 0, C_NONE, 0, 0);
    checkOutput();
    applyStimulus("lu_lui", 0, lui(5), load(5, 1), 0, 0, 0, C_NONE, 0, 0);
    checkOutput();
    applyStimulus("lu_store_rs2", 0, store(5, 1), load(5, 1), 0, 0, 0, C_LU, 0, 0);
    checkOutput();

    // Branch squashes the dependent instruction instead of stalling.
    applyStimulus("br_over_lu", 0, r_type(6, 5, 2), load(5, 1), 1, 0, 0, C_BR, 0, 0);
    checkOutput();

    applyStimulus("mw_enter", 0, r_type(6, 5, 2), NOP, 0, 1, 0, C_FRZ, 0, 0);
    checkOutput();
    applyStimulus("mw_wait1", 0, r_type(6, 5, 2), NOP, 0, 1, 0, C_FRZ, 1, 0);
    checkOutput();
    applyStimulus("mw_wait2", 0, r_type(6, 5, 2), NOP, 0, 1, 0, C_FRZ, 1, 0);
    checkOutput();
    applyStimulus("mw_ready", 0, r_type(6, 5, 2), NOP, 0, 1, 1, C_NONE, 1, 0);
    checkOutput();
    applyStimulus("mw_back_run", 0, r_type(6, 5, 2), NOP, 0, 0, 0, C_NONE, 0, 0);
    checkOutput();

    applyStimulus("bf_enter", 0, NOP, NOP, 1, 1, 0, C_FRZ, 0, 0);
    checkOutput();
    applyStimulus("bf_wait", 0, NOP, NOP, 1, 1, 0, C_FRZ, 1, 0);
    checkOutput();
    applyStimulus("bf_ready", 0, NOP, NOP, 1, 1, 1, C_BR, 1, 0);
    checkOutput();
    applyStimulus("bf_quiet", 0, NOP, NOP, 0, 0, 0, C_NONE, 0, 0);
    checkOutput();

    // Four MEM_WAIT cycles with the wait counter at 1..4, then the trap.
    applyStimulus("to_enter", 0, NOP, NOP, 0, 1, 0, C_FRZ, 0, 0);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus("to_wait", 0, NOP, NOP, 0, 1, 0, C_FRZ, 1, 0);
      checkOutput();
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus("err_hold", 0, NOP, NOP, 0, 1, 1, C_FRZ, 2, 1);
      checkOutput();
    end

    // Reset asserted mid-cycle must clear state before the next edge.
    applyStimulus("rst_async_err", 1, NOP, NOP, 0, 1, 1, C_NONE, 0, 0);
    checkOutput();
    applyStimulus("post_rst_err", 0, NOP, NOP, 0, 0, 0, C_NONE, 0, 0);
    checkOutput();

    applyStimulus("mw2_enter", 0, NOP, NOP, 0, 1, 0, C_FRZ, 0, 0);
    checkOutput();
    applyStimulus("mw2_wait", 0, NOP, NOP, 0, 1, 0, C_FRZ, 1, 0);
    checkOutput();
    applyStimulus("rst_async_mw", 1, NOP, NOP, 0, 1, 0, C_NONE, 0, 0);
    checkOutput();
    applyStimulus("post_rst_mw", 0, NOP, NOP, 0, 0, 0, C_NONE, 0, 0);
    checkOutput();
    applyStimulus("lu_after_rst", 0, r_type(6, 2, 7), load(7, 3), 0, 0, 0, C_LU, 0, 0);
    checkOutput();
    applyStimulus("cnt_after_rst", 0, NOP, NOP, 0, 0, 0, C_NONE, 0, 0);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
